// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD up/down counter with built-in prescaler clock-enable, synchronous load,
// and registered one-cycle step (tick_out) and full-wrap (wrap) pulses.
module bcd_cascade_counter #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 25_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick_out,
  output logic                  wrap
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]      r_ps_cnt;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_tick;
  logic                 r_wrap;

  logic [4*DIGITS-1:0]  w_bcd_nxt;
  logic [4*DIGITS-1:0]  w_load_clamped;
  logic [4:0]           w_dig;
  logic                 w_carry;
  logic                 w_step;

  // Returns {carry_or_borrow, new_digit} for one digit stepped in the given direction.
  function automatic logic [4:0] step_digit(input logic [3:0] d, input logic dir_up);
    logic [4:0] res;
    if (dir_up) begin
      if (d >= 4'd9) res = {1'b1, 4'd0};
      else           res = {1'b0, d + 4'd1};
    end else begin
      if (d == 4'd0)     res = {1'b1, 4'd9};
      else if (d > 4'd9) res = {1'b0, 4'd8};
      else               res = {1'b0, d - 4'd1};
    end
    return res;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    logic [3:0] res;
    if (d > 4'd9) res = 4'd9;
    else          res = d;
    return res;
  endfunction

  assign w_step = en && (r_ps_cnt == PS_MAX);

  // Ripple the carry/borrow through all digits and clamp the load value.
  always_comb begin
    w_carry        = 1'b1;
    w_dig          = 5'd0;
    w_bcd_nxt      = r_bcd;
    w_load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
      if (w_carry) begin
        w_dig                = step_digit(r_bcd[4*i +: 4], up);
        w_bcd_nxt[4*i +: 4]  = w_dig[3:0];
        w_carry              = w_dig[4];
      end else begin
        w_bcd_nxt[4*i +: 4]  = r_bcd[4*i +: 4];
      end
    end
  end

  // Prescaler, digit register and pulse outputs; reset > load > step > hold.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_ps_cnt <= '0;
      r_bcd    <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (load) begin
      r_ps_cnt <= '0;
      r_bcd    <= w_load_clamped;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (w_step) begin
      r_ps_cnt <= '0;
      r_bcd    <= w_bcd_nxt;
      r_tick   <= 1'b1;
      r_wrap   <= w_carry;
    end else if (en) begin
      r_ps_cnt <= r_ps_cnt + PS_W'(1);
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end
  end

  assign bcd      = r_bcd;
  assign tick_out = r_tick;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: two counters (2 digits / prescale 4, and 3 digits / prescale 1) checked
// every cycle against an integer-arithmetic model, with directed steps then random stimulus.
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        rst_n, en, up, load;
  logic [7:0]  lv_a;
  logic [11:0] lv_b;
  logic [7:0]  bcd_a;
  logic [11:0] bcd_b;
  logic        tick_a, wrap_a, tick_b, wrap_b;

  int n_vec = 0;
  int n_err = 0;

  int m_val  [2];
  int m_ps   [2];
  int m_tick [2];
  int m_wrap [2];

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(2), .PRESCALE(4)) u_a (
    .clk_in(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(lv_a), .bcd(bcd_a), .tick_out(tick_a), .wrap(wrap_a)
  );

  bcd_cascade_counter #(.DIGITS(3), .PRESCALE(1)) u_b (
    .clk_in(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(lv_b), .bcd(bcd_b), .tick_out(tick_b), .wrap(wrap_b)
  );

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int x;
    r = 32'd0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [31:0] lv, input int nd);
    int v, d, w;
    v = 0;
    w = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_edge(input int k, input logic [31:0] lv);
    int m, p, nd;
    nd = (k == 0) ? 2 : 3;
    m  = (k == 0) ? 100 : 1000;
    p  = (k == 0) ? 4 : 1;
    if (!rst_n) begin
      m_val[k] = 0; m_ps[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_val[k] = from_load(lv, nd); m_ps[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (en) begin
      if (m_ps[k] == p - 1) begin
        m_ps[k]   = 0;
        m_tick[k] = 1;
        m_wrap[k] = up ? int'(m_val[k] == m - 1) : int'(m_val[k] == 0);
        m_val[k]  = up ? (m_val[k] + 1) % m : (m_val[k] + m - 1) % m;
      end else begin
        m_ps[k]++; m_tick[k] = 0; m_wrap[k] = 0;
      end
    end else begin
      m_tick[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0, {24'd0, lv_a});
    model_edge(1, {20'd0, lv_b});
    #1;
    check("bcd_a",  {24'd0, bcd_a},  to_bcd(m_val[0], 2));
    check("tick_a", {31'd0, tick_a}, 32'(m_tick[0]));
    check("wrap_a", {31'd0, wrap_a}, 32'(m_wrap[0]));
    check("bcd_b",  {20'd0, bcd_b},  to_bcd(m_val[1], 3));
    check("tick_b", {31'd0, tick_b}, 32'(m_tick[1]));
    check("wrap_b", {31'd0, wrap_b}, 32'(m_wrap[1]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1;
    lv_a = 8'h55; lv_b = 12'h555;
    foreach (m_val[k]) begin
      m_val[k] = 0; m_ps[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end

    // Reset beats load
    run(2);
    check("rst_bcd", {24'd0, bcd_a}, 32'h00);

    // Count up from zero through the full wrap
    rst_n = 1'b1; load = 1'b0; up = 1'b1;
    run(3);
    check("first_hold", {24'd0, bcd_a}, 32'h00);
    cyc();
    check("first_step", {24'd0, bcd_a}, 32'h01);
    check("first_tick", {31'd0, tick_a}, 32'd1);
    run(396);
    check("up_wrap_bcd", {24'd0, bcd_a}, 32'h00);
    check("up_wrap", {31'd0, wrap_a}, 32'd1);

    // Down from 00 wraps to 99, then 98 without wrap
    load = 1'b1; lv_a = 8'h00; lv_b = 12'h000; up = 1'b0;
    cyc();
    load = 1'b0;
    run(4);
    check("dn_wrap_bcd", {24'd0, bcd_a}, 32'h99);
    check("dn_wrap", {31'd0, wrap_a}, 32'd1);
    run(4);
    check("dn_98", {24'd0, bcd_a}, 32'h98);
    check("dn_98_wrap", {31'd0, wrap_a}, 32'd0);

    // Mid-period load restarts the prescaler
    up = 1'b1;
    run(2);
    load = 1'b1; lv_a = 8'h57;
    cyc();
    check("load57", {24'd0, bcd_a}, 32'h57);
    check("load57_tick", {31'd0, tick_a}, 32'd0);
    load = 1'b0;
    run(3);
    check("load57_hold", {24'd0, bcd_a}, 32'h57);
    cyc();
    check("load57_step", {24'd0, bcd_a}, 32'h58);

    // en low freezes a partial prescale count
    run(2);
    en = 1'b0;
    run(10);
    check("frozen", {24'd0, bcd_a}, 32'h58);
    en = 1'b1;
    cyc();
    check("resume_hold", {24'd0, bcd_a}, 32'h58);
    cyc();
    check("resume_step", {24'd0, bcd_a}, 32'h59);

    // Out-of-range load digits clamp to 9
    load = 1'b1; lv_a = 8'hA3; lv_b = 12'hFB2;
    cyc();
    check("clamp_a", {24'd0, bcd_a}, 32'h93);
    check("clamp_b", {20'd0, bcd_b}, 32'h992);
    load = 1'b0;

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) < 8);
      up    = $urandom_range(0, 1) != 0;
      load  = ($urandom_range(0, 19) == 0);
      lv_a  = 8'($urandom);
      lv_b  = 12'($urandom);
      cyc();
    end

    // Three digits, prescale 1: 000 -> 999 -> 000
    rst_n = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; lv_a = 8'h00; lv_b = 12'h000;
    cyc();
    load = 1'b0;
    run(999);
    check("b_999", {20'd0, bcd_b}, 32'h999);
    check("b_tick", {31'd0, tick_b}, 32'd1);
    cyc();
    check("b_wrap_bcd", {20'd0, bcd_b}, 32'h000);
    check("b_wrap", {31'd0, wrap_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
